// File: rtl/arith_pkg.sv
// Shared arithmetic sizing for the datapath multiplier.
package arith_pkg;
    localparam int MUL_WIDTH  = 8;
    localparam int PROD_WIDTH = 2 * MUL_WIDTH;
endpackage

// File: rtl/mul_fa_cell.sv
// One array-multiplier cell: partial-product AND followed by a full adder.
module mul_fa_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic sum_in,
    input  logic cin,
    output logic sum_out,
    output logic cout
);
    logic pp;

    assign pp      = a_bit & b_bit;
    assign sum_out = pp ^ sum_in ^ cin;
    assign cout    = (pp & sum_in) | (cin & (pp ^ sum_in));
endmodule

// File: rtl/array_multiplier_8x8.sv
// Unsigned carry-save array multiplier with a ripple final row and one output register.
module array_multiplier_8x8
    import arith_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);
    // Row i, cell j carries weight i+j; carries carry weight i+j+1.
    logic [WIDTH-1:0][WIDTH-1:0] s_row;
    logic [WIDTH-1:0][WIDTH-1:0] c_row;
    logic [WIDTH-1:0]            hi_sum;
    logic [2*WIDTH-1:0]          prod_d;

    assign s_row[0] = a & {WIDTH{b[0]}};
    assign c_row[0] = '0;

    for (genvar i = 1; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            logic sum_in;
            if (j == WIDTH - 1) begin : g_top
                assign sum_in = 1'b0;
            end else begin : g_mid
                assign sum_in = s_row[i-1][j+1];
            end
            mul_fa_cell u_cell (
                .a_bit  (a[j]),
                .b_bit  (b[i]),
                .sum_in (sum_in),
                .cin    (c_row[i-1][j]),
                .sum_out(s_row[i][j]),
                .cout   (c_row[i][j])
            );
        end
    end

    // Leftover sum bits of the last row line up with its carries at weight WIDTH.
    assign hi_sum = {1'b0, s_row[WIDTH-1][WIDTH-1:1]};

    always_comb begin
        logic carry;
        prod_d = '0;
        carry  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            prod_d[i] = s_row[i][0];
        end
        for (int k = 0; k < WIDTH; k++) begin
            prod_d[WIDTH+k] = hi_sum[k] ^ c_row[WIDTH-1][k] ^ carry;
            carry = (hi_sum[k] & c_row[WIDTH-1][k]) | (carry & (hi_sum[k] ^ c_row[WIDTH-1][k]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else begin
            product <= prod_d;
        end
    end
endmodule

// File: tb/tb_array_multiplier_8x8.sv
// Self-checking bench: directed boundaries, back-to-back stream and random sweep with mid-run reset.
module tb_array_multiplier_8x8;
    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;

    int n_chk  = 0;
    int n_fail = 0;

    array_multiplier_8x8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Apply operands just after an edge, then check one edge later.
    task automatic step(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        chk(tag, product, exp);
    endtask

    logic [7:0]  da [8] = '{8'h04, 8'h0C, 8'h00, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h80};
    logic [7:0]  db [8] = '{8'h02, 8'h03, 8'hA5, 8'hA5, 8'h02, 8'h01, 8'hFF, 8'h80};
    logic [15:0] dp [8] = '{16'h0008, 16'h0024, 16'h0000, 16'h00A5,
                            16'h0100, 16'h00FF, 16'hFE01, 16'h4000};

    initial begin
        logic [7:0]  x, y;
        logic [15:0] prev;

        rst_n = 1'b0;
        a = 8'hFF;
        b = 8'hFF;
        #3;
        chk("reset_async", product, 16'h0000);
        @(posedge clk);
        #1;
        chk("reset_hold", product, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", product, 16'hFE01);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("directed_%0d", i), da[i], db[i], dp[i]);
        end

        // Stream: new pair every cycle; output must hold until the next edge.
        prev = product;
        for (int i = 0; i < 16; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            a = x;
            b = y;
            #3;
            chk($sformatf("stream_hold_%0d", i), product, prev);
            @(posedge clk);
            #1;
            chk($sformatf("stream_%0d", i), product, ref_mul(x, y));
            prev = ref_mul(x, y);
        end

        for (int i = 0; i < 12000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (i == 5000) begin
                a = 8'hFF;
                b = 8'hFF;
                #2;
                rst_n = 1'b0;
                #1;
                chk("mid_rst_async", product, 16'h0000);
                @(posedge clk);
                #1;
                chk("mid_rst_hold", product, 16'h0000);
                rst_n = 1'b1;
                step("mid_rst_recover", x, y, ref_mul(x, y));
            end else begin
                step("random", x, y, ref_mul(x, y));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
